// File: rtl/stage2_rx_fsm_if.sv
// Beat-stream bundle between the encoded-beat source, the stage-2 receive FSM
// and the stage-1 receive logic downstream of it.
interface stage2_rx_fsm_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_data;
  logic [1:0]           in_state;
  logic [1:0]           key_bits;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic [15:0]          out_mask;
  logic [1:0]           out_mode;
  logic                 out_err;
  logic                 sync_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  // master: beat source / downstream sink side
  modport master (
    output in_valid, in_data, in_state, key_bits, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_mode,
           out_err, sync_err, locked, err_count
  );

  // slave: the receive FSM itself
  modport slave (
    input  in_valid, in_data, in_state, key_bits, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_mode,
           out_err, sync_err, locked, err_count
  );
endinterface

// File: rtl/stage2_rx_fsm.sv
// Stage-2 receive FSM: replays the encoder state machine from key_bits, recovers
// surviving plaintext bits, flags format/sync errors, single-register output stage.
module stage2_rx_fsm #(
  parameter int unsigned RESYNC_THRESH = 3,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  stage2_rx_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } rep_state_e;

  localparam logic [3:0]           THRESH  = 4'(RESYNC_THRESH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  rep_state_e           rep_q, rep_d;
  logic [3:0]           mm_q, mm_d;

  logic                 out_valid_q, out_valid_d;
  logic [15:0]          out_data_q, out_data_d;
  logic [15:0]          out_mask_q, out_mask_d;
  logic [1:0]           out_mode_q, out_mode_d;
  logic                 out_err_q, out_err_d;
  logic                 sync_err_q, sync_err_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 in_ready;
  logic                 accept;
  rep_state_e           pred;
  logic                 mismatch;
  logic [3:0]           mm_inc;
  logic [15:0]          dec_data;
  logic [15:0]          dec_mask;
  logic                 fmt_err;

  assign in_ready = rst_n & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Encoder transition: next state is the key XOR a per-state constant.
  always_comb begin
    pred = S0;
    case (rep_q)
      S0: pred = rep_state_e'(bus.key_bits ^ 2'b01);
      S1: pred = rep_state_e'(bus.key_bits ^ 2'b10);
      S2: pred = rep_state_e'(bus.key_bits ^ 2'b11);
      S3: pred = rep_state_e'(bus.key_bits);
      default: pred = S0;
    endcase
  end

  assign mismatch = (bus.in_state != pred);
  assign mm_inc   = mm_q + 4'd1;

  // Per-mode plaintext recovery and format check.
  always_comb begin
    dec_data = '0;
    dec_mask = '0;
    fmt_err  = 1'b0;
    case (rep_q)
      S0: begin
        dec_data = {15'b0, bus.in_data[0]};
        dec_mask = 16'h0001;
        fmt_err  = |bus.in_data[15:1];
      end
      S1: begin
        dec_data = bus.in_data & 16'hAAAA;
        dec_mask = 16'hAAAA;
        fmt_err  = (bus.in_data & 16'h5555) != 16'h0000;
      end
      S2: begin
        dec_data = bus.in_data & 16'hAAAA;
        dec_mask = 16'hAAAA;
        fmt_err  = (bus.in_data & 16'h5555) != 16'h5555;
      end
      S3: begin
        dec_data = {bus.in_data[15], 3'b000, bus.in_data[11:0]};
        dec_mask = 16'h8FFF;
        fmt_err  = ~((&bus.in_data[15:12]) | ~(|bus.in_data[15:12]));
      end
      default: begin
        dec_data = '0;
        dec_mask = '0;
        fmt_err  = 1'b0;
      end
    endcase
  end

  // Replica next-state: follow prediction, adopt the received tag after
  // THRESH consecutive mismatches.
  always_comb begin
    rep_d = rep_q;
    mm_d  = mm_q;
    if (accept) begin
      if (!mismatch) begin
        rep_d = pred;
        mm_d  = '0;
      end else if (mm_inc == THRESH) begin
        rep_d = rep_state_e'(bus.in_state);
        mm_d  = '0;
      end else begin
        rep_d = pred;
        mm_d  = mm_inc;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    sync_err_d  = sync_err_q;
    locked_d    = locked_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = dec_data;
      out_mask_d  = dec_mask;
      out_mode_d  = rep_q;
      out_err_d   = fmt_err;
      sync_err_d  = mismatch;
      locked_d    = (mm_d == 4'd0);
      if ((fmt_err || mismatch) && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_q       <= S0;
      mm_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mask_q  <= '0;
      out_mode_q  <= '0;
      out_err_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      locked_q    <= 1'b1;
      err_cnt_q   <= '0;
    end else begin
      rep_q       <= rep_d;
      mm_q        <= mm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mask_q  <= out_mask_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
      sync_err_q  <= sync_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_err   = out_err_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.locked    = locked_q;
  assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_stage2_rx_fsm.sv
// Bench for stage2_rx_fsm: directed beats, per-cycle comparison against an
// arithmetic reference model, and hand-computed literal expectations.
module tb_stage2_rx_fsm;

  localparam int THRESH = 3;
  localparam int CW     = 8;
  localparam int CMAX   = (1 << CW) - 1;

  logic clk;
  logic rst_n;

  stage2_rx_fsm_if #(.ERR_CNT_W(CW)) bus ();

  stage2_rx_fsm #(
    .RESYNC_THRESH(THRESH),
    .ERR_CNT_W    (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: expected registered outputs and replica state.
  int m_valid = 0, m_data = 0, m_mask = 0, m_mode = 0, m_err = 0, m_sync = 0;
  int m_locked = 1, m_cnt = 0, m_rep = 0, m_mm = 0;
  int q_data[$];
  int delivered = 0;
  bit started = 0;
  int mask_tab[4] = '{32'h0001, 32'hAAAA, 32'hAAAA, 32'h8FFF};

  function automatic int fmt_bad(input int mode, input int d);
    case (mode)
      0:       return ((d & 32'hFFFE) != 0) ? 1 : 0;
      1:       return ((d & 32'h5555) != 0) ? 1 : 0;
      2:       return ((d & 32'h5555) != 32'h5555) ? 1 : 0;
      default: return ((d >> 12) == 0 || (d >> 12) == 15) ? 0 : 1;
    endcase
  endfunction

  always @(posedge clk) begin
    int pred, d;
    started = 1;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_mask = 0; m_mode = 0; m_err = 0; m_sync = 0;
      m_locked = 1; m_cnt = 0; m_rep = 0; m_mm = 0;
      q_data.delete();
    end else if (bus.in_valid && (m_valid == 0 || bus.out_ready)) begin
      d      = int'(bus.in_data);
      pred   = int'(bus.key_bits) ^ ((m_rep + 1) % 4);
      m_mode = m_rep;
      m_mask = mask_tab[m_rep];
      m_data = d & m_mask;
      m_err  = fmt_bad(m_rep, d);
      m_sync = (int'(bus.in_state) != pred) ? 1 : 0;
      if (m_sync == 0) begin
        m_rep = pred; m_mm = 0;
      end else begin
        m_mm++;
        if (m_mm == THRESH) begin
          m_rep = int'(bus.in_state); m_mm = 0;
        end else begin
          m_rep = pred;
        end
      end
      m_locked = (m_mm == 0) ? 1 : 0;
      if ((m_err != 0 || m_sync != 0) && m_cnt < CMAX) m_cnt++;
      m_valid = 1;
      q_data.push_back(m_data);
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", bus.in_ready, (rst_n && (m_valid == 0 || bus.out_ready)) ? 1 : 0);
      check("out_valid", bus.out_valid, m_valid);
      check("locked", bus.locked, m_locked);
      check("err_count", bus.err_count, m_cnt);
      if (m_valid != 0) begin
        check("out_data", bus.out_data, m_data);
        check("out_mask", bus.out_mask, m_mask);
        check("out_mode", bus.out_mode, m_mode);
        check("out_err", bus.out_err, m_err);
        check("sync_err", bus.sync_err, m_sync);
      end
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q_data.size() == 0) begin
          check("deliver_nonempty", 0, 1);
        end else begin
          check("deliver_order", bus.out_data, q_data.pop_front());
        end
        delivered++;
      end
    end
  end

  task automatic wait_accept();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", ok, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] st, input logic [1:0] k);
    bus.in_data  = d;
    bus.in_state = st;
    bus.key_bits = k;
    bus.in_valid = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int d0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_state  = '0;
    bus.key_bits  = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_err_count", bus.err_count, 0);
    check("rst_locked", bus.locked, 1);
    rst_n = 1'b1;

    // S0 decode, no errors
    send(16'h0001, 2'd1, 2'd0);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 32'h0001);
    check("t1_mask", bus.out_mask, 32'h0001);
    check("t1_mode", bus.out_mode, 0);
    check("t1_errs", {bus.out_err, bus.sync_err}, 0);
    check("t1_model_rep", m_rep, 1);

    // S1 decode, clean and with format error
    send(16'hAAAA, 2'd2, 2'd0);
    check("t2a_data", bus.out_data, 32'hAAAA);
    check("t2a_mask", bus.out_mask, 32'hAAAA);
    check("t2a_mode", bus.out_mode, 1);
    check("t2a_errs", {bus.out_err, bus.sync_err}, 0);
    do_reset();
    send(16'h0001, 2'd1, 2'd0);
    send(16'hAAAB, 2'd2, 2'd0);
    check("t2b_err", bus.out_err, 1);
    check("t2b_sync", bus.sync_err, 0);
    check("t2b_data", bus.out_data, 32'hAAAA);
    check("t2b_cnt", bus.err_count, 1);

    // S3 decode, clean and with format error
    send(16'h5555, 2'd3, 2'd0);
    check("t3_s2_err", bus.out_err, 0);
    send(16'hF123, 2'd0, 2'd0);
    check("t3a_mode", bus.out_mode, 3);
    check("t3a_data", bus.out_data, 32'h8123);
    check("t3a_mask", bus.out_mask, 32'h8FFF);
    check("t3a_err", bus.out_err, 0);
    send(16'h0000, 2'd3, 2'd2);
    check("t3_key_sync", bus.sync_err, 0);
    send(16'hA123, 2'd0, 2'd0);
    check("t3b_mode", bus.out_mode, 3);
    check("t3b_err", bus.out_err, 1);
    check("t3b_cnt", bus.err_count, 2);

    // Resync after THRESH mismatches
    do_reset();
    send(16'h0000, 2'd0, 2'd0);
    check("t4_b1_sync", bus.sync_err, 1);
    check("t4_b1_err", bus.out_err, 0);
    check("t4_b1_locked", bus.locked, 0);
    send(16'h0000, 2'd0, 2'd0);
    check("t4_b2_sync", bus.sync_err, 1);
    check("t4_b2_err", bus.out_err, 0);
    check("t4_b2_locked", bus.locked, 0);
    send(16'h5555, 2'd0, 2'd0);
    check("t4_b3_sync", bus.sync_err, 1);
    check("t4_b3_err", bus.out_err, 0);
    check("t4_b3_locked", bus.locked, 1);
    check("t4_cnt", bus.err_count, 3);
    check("t4_model_rep", m_rep, 0);
    send(16'h0001, 2'd1, 2'd0);
    check("t4_next_mode", bus.out_mode, 0);
    check("t4_next_sync", bus.sync_err, 0);

    // Backpressure: nothing lost or duplicated
    do_reset();
    d0 = delivered;
    bus.out_ready = 1'b0;
    send(16'h0001, 2'd1, 2'd0);
    bus.in_data  = 16'hAAAA;
    bus.in_state = 2'd2;
    bus.key_bits = 2'd0;
    bus.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t5_stall_ready", bus.in_ready, 0);
      check("t5_stall_data", bus.out_data, 32'h0001);
      check("t5_stall_valid", bus.out_valid, 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept();
    check("t5_b_data", bus.out_data, 32'hAAAA);
    send(16'h5555, 2'd3, 2'd0);
    send(16'h0FFF, 2'd0, 2'd0);
    check("t5_d_data", bus.out_data, 32'h0FFF);
    repeat (3) @(posedge clk);
    #1;
    check("t5_delivered", delivered - d0, 4);
    check("t5_queue_empty", q_data.size(), 0);

    // Reset mid-stream with a pending beat
    do_reset();
    send(16'h0002, 2'd1, 2'd0);
    send(16'h0001, 2'd2, 2'd0);
    send(16'h0000, 2'd3, 2'd0);
    send(16'h7000, 2'd0, 2'd0);
    send(16'h0002, 2'd1, 2'd0);
    bus.out_ready = 1'b0;
    check("t6_pre_valid", bus.out_valid, 1);
    check("t6_pre_cnt", bus.err_count, 5);
    do_reset();
    check("t6_valid", bus.out_valid, 0);
    check("t6_cnt", bus.err_count, 0);
    check("t6_locked", bus.locked, 1);
    bus.out_ready = 1'b1;
    send(16'h0001, 2'd1, 2'd0);
    check("t6_mode", bus.out_mode, 0);
    check("t6_sync", bus.sync_err, 0);
    check("t6_data", bus.out_data, 32'h0001);

    // err_count saturation: 0x7001 is malformed in every mode
    do_reset();
    for (int i = 0; i < 260; i++) begin
      send(16'h7001, 2'(i), 2'(i >> 2));
    end
    check("t7_sat", bus.err_count, 32'hFF);
    check("t7_err", bus.out_err, 1);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
